// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory arbiter slice.
package dmem_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  localparam int unsigned WORD_BYTES = 4;

  localparam logic P_CPU = 1'b0;
  localparam logic P_LDR = 1'b1;

endpackage

// File: rtl/dmem_arb_pick.sv
// Combinational winner selection between the two requesters.
// On a tie the port named by rr_ptr wins.
module dmem_arb_pick
  import dmem_pkg::*;
(
  input  logic req0,
  input  logic req1,
  input  logic rr_ptr,
  output logic winner,
  output logic any_req
);

  always_comb begin
    any_req = req0 | req1;
    winner  = P_CPU;
    if (req0 && req1) begin
      winner = rr_ptr;
    end else if (req1) begin
      winner = P_LDR;
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port arbiter/sequencer in front of the single-port data memory.
// Define ROUND_ROBIN_EN for alternating tie-break; otherwise port 0 has fixed priority.
module dmem_arbiter
  import dmem_pkg::*;
#(
  parameter int unsigned AW          = 32,
  parameter int unsigned DEPTH_BYTES = 12
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req0,
  input  logic          req1,
  input  logic          we0,
  input  logic          we1,
  input  logic [AW-1:0] addr0,
  input  logic [AW-1:0] addr1,
  input  logic [31:0]   wdata0,
  input  logic [31:0]   wdata1,
  output logic          gnt0,
  output logic          gnt1,
  output logic          done0,
  output logic          done1,
  output logic          err0,
  output logic          err1,
  output logic [31:0]   rdata0,
  output logic [31:0]   rdata1,
  output logic [AW-1:0] mem_addr,
  output logic [31:0]   mem_wdata,
  output logic          mem_write,
  output logic          mem_read,
  input  logic [31:0]   mem_rdata
);

  localparam logic [AW:0] LAST_WORD = (AW+1)'(DEPTH_BYTES - WORD_BYTES);

  state_t        state_q, state_d;
  logic [AW-1:0] addr_q, addr_d;
  logic          we_q, we_d;
  logic [31:0]   wdata_q, wdata_d;
  logic [31:0]   rdata_q, rdata_d;
  logic          owner_q, owner_d;
  logic          err_q, err_d;

  logic          rr_ptr;
  logic          winner;
  logic          any_req;
  logic [AW-1:0] sel_addr;
  logic          sel_we;
  logic [31:0]   sel_wdata;
  logic          addr_bad;
  logic          grant;

  dmem_arb_pick u_pick (
    .req0    (req0),
    .req1    (req1),
    .rr_ptr  (rr_ptr),
    .winner  (winner),
    .any_req (any_req)
  );

`ifdef ROUND_ROBIN_EN
  logic rr_q, rr_d;

  // Pointer names the port preferred on the next tie: the one that did not just win.
  always_comb begin
    rr_d = rr_q;
    if (state_q == IDLE && any_req) begin
      rr_d = ~winner;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) rr_q <= P_CPU;
    else     rr_q <= rr_d;
  end

  assign rr_ptr = rr_q;
`else
  assign rr_ptr = P_CPU;
`endif

  always_comb begin
    sel_addr  = (winner == P_LDR) ? addr1  : addr0;
    sel_we    = (winner == P_LDR) ? we1    : we0;
    sel_wdata = (winner == P_LDR) ? wdata1 : wdata0;
    // Widened compare so addresses near 2**AW cannot wrap into range.
    addr_bad  = (sel_addr[1:0] != 2'b00) || ({1'b0, sel_addr} > LAST_WORD);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      addr_q  <= '0;
      we_q    <= 1'b0;
      wdata_q <= '0;
      rdata_q <= '0;
      owner_q <= P_CPU;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      we_q    <= we_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      owner_q <= owner_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    we_d    = we_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    owner_d = owner_q;
    err_d   = err_q;
    case (state_q)
      IDLE: begin
        if (any_req) begin
          addr_d  = sel_addr;
          we_d    = sel_we;
          wdata_d = sel_wdata;
          owner_d = winner;
          err_d   = addr_bad;
          state_d = addr_bad ? RESP : ACCESS;
        end
      end
      ACCESS: begin
        rdata_d = mem_rdata;
        state_d = RESP;
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    grant     = (state_q == IDLE) && any_req && !rst;
    gnt0      = grant && (winner == P_CPU);
    gnt1      = grant && (winner == P_LDR);
    done0     = (state_q == RESP) && (owner_q == P_CPU);
    done1     = (state_q == RESP) && (owner_q == P_LDR);
    err0      = done0 && err_q;
    err1      = done1 && err_q;
    rdata0    = (done0 && !err_q && !we_q) ? rdata_q : '0;
    rdata1    = (done1 && !err_q && !we_q) ? rdata_q : '0;
    mem_addr  = addr_q;
    mem_wdata = wdata_q;
    mem_write = (state_q == ACCESS) && we_q;
    mem_read  = (state_q == ACCESS) && !we_q;
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter with a word-level reference memory.
module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        req0, req1, we0, we1;
  logic [31:0] addr0, addr1, wdata0, wdata1;
  logic        gnt0, gnt1, done0, done1, err0, err1;
  logic [31:0] rdata0, rdata1;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_write, mem_read;

  logic [7:0]  mem_b   [0:11];
  logic [31:0] ref_mem [0:2];
  int          errors  = 0;
  int          nchecks = 0;

  always #5 clk = ~clk;

  dmem_arbiter #(.AW(32), .DEPTH_BYTES(12)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .gnt0(gnt0), .gnt1(gnt1), .done0(done0), .done1(done1),
    .err0(err0), .err1(err1), .rdata0(rdata0), .rdata1(rdata1),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_write(mem_write), .mem_read(mem_read), .mem_rdata(mem_rdata)
  );

  // Big-endian byte memory behind the arbiter
  logic [3:0] ma;
  assign ma = mem_addr[3:0];
  always_comb begin
    mem_rdata = '0;
    if (mem_addr <= 32'd8)
      mem_rdata = {mem_b[ma], mem_b[ma+4'd1], mem_b[ma+4'd2], mem_b[ma+4'd3]};
  end
  always @(posedge clk) begin
    if (mem_write && mem_addr <= 32'd8) begin
      mem_b[ma]      <= mem_wdata[31:24];
      mem_b[ma+4'd1] <= mem_wdata[23:16];
      mem_b[ma+4'd2] <= mem_wdata[15:8];
      mem_b[ma+4'd3] <= mem_wdata[7:0];
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int p, input logic r, input logic w,
                       input logic [31:0] a, input logic [31:0] d);
    if (p == 0) begin req0 = r; we0 = w; addr0 = a; wdata0 = d; end
    else        begin req1 = r; we1 = w; addr1 = a; wdata1 = d; end
  endtask

  function automatic logic other_quiet(input int p);
    if (p == 0) return !(gnt1 || done1 || err1 || (rdata1 != 32'd0));
    else        return !(gnt0 || done0 || err0 || (rdata0 != 32'd0));
  endfunction

  task automatic run_txn(input int p, input logic w, input logic [31:0] a,
                         input logic [31:0] d, input string nm);
    bit          bad, got, fin, quiet;
    int          lat, wr_n, rd_n, strobe_cyc;
    logic [31:0] exp_rd, act_rd, strobe_addr;
    logic        act_err;
    bad    = ((a & 32'd3) != 0) || (a > 32'd8);
    exp_rd = (!bad && !w) ? ref_mem[a >> 2] : 32'd0;
    if (!bad && w) ref_mem[a >> 2] = d;
    drive(p, 1'b1, w, a, d);
    got = 0; quiet = 1;
    for (int i = 0; i < 8 && !got; i++) begin
      @(negedge clk);
      if ((p == 0) ? gnt0 : gnt1) begin got = 1; quiet = other_quiet(p); end
    end
    nchecks++;
    if (!got) begin
      errors++;
      $display("FAIL %s gnt_timeout: no grant seen within 8 cycles, required a grant", nm);
      drive(p, 1'b0, 1'b0, 32'd0, 32'd0);
      step();
      return;
    end
    fin = 0; lat = 0; wr_n = 0; rd_n = 0; strobe_cyc = 0;
    strobe_addr = 0; act_err = 0; act_rd = 0;
    for (int i = 1; i <= 6 && !fin; i++) begin
      @(negedge clk);
      if (mem_write) begin wr_n++; strobe_cyc = i; strobe_addr = mem_addr; end
      if (mem_read)  begin rd_n++; strobe_cyc = i; strobe_addr = mem_addr; end
      if (!other_quiet(p)) quiet = 0;
      if ((p == 0) ? done0 : done1) begin
        fin = 1; lat = i;
        act_err = (p == 0) ? err0 : err1;
        act_rd  = (p == 0) ? rdata0 : rdata1;
      end
    end
    nchecks++;
    if (lat != (bad ? 1 : 2)) begin
      errors++;
      $display("FAIL %s latency: got %0d cycles, required %0d", nm, lat, bad ? 1 : 2);
    end
    nchecks++;
    if (act_err !== bad) begin
      errors++;
      $display("FAIL %s err: got %0b, required %0b", nm, act_err, bad);
    end
    nchecks++;
    if (act_rd !== exp_rd) begin
      errors++;
      $display("FAIL %s rdata: got %h, required %h", nm, act_rd, exp_rd);
    end
    nchecks++;
    if (wr_n != ((!bad && w) ? 1 : 0) || rd_n != ((!bad && !w) ? 1 : 0)) begin
      errors++;
      $display("FAIL %s mem_strobes: got wr=%0d rd=%0d, required wr=%0d rd=%0d",
               nm, wr_n, rd_n, (!bad && w) ? 1 : 0, (!bad && !w) ? 1 : 0);
    end
    if (!bad) begin
      nchecks++;
      if (strobe_cyc != 1 || strobe_addr !== a) begin
        errors++;
        $display("FAIL %s access_cycle: got cycle %0d addr %h, required cycle 1 addr %h",
                 nm, strobe_cyc, strobe_addr, a);
      end
    end
    nchecks++;
    if (!quiet) begin
      errors++;
      $display("FAIL %s other_port: got non-zero outputs on port %0d, required all 0", nm, 1 - p);
    end
    step();
    drive(p, 1'b0, 1'b0, 32'd0, 32'd0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive(0, 1'b1, 1'b1, 32'd4, 32'hFFFF_FFFF);
    drive(1, 1'b1, 1'b0, 32'd8, 32'd0);
    #2;
    nchecks++;
    if ({gnt0, gnt1, done0, done1, err0, err1, rdata0, rdata1, mem_addr, mem_wdata,
         mem_write, mem_read} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got gnt=%b%b done=%b%b mw=%b mr=%b addr=%h, required all 0",
               gnt0, gnt1, done0, done1, mem_write, mem_read, mem_addr);
    end
    step();
    drive(0, 1'b0, 1'b0, 32'd0, 32'd0);
    drive(1, 1'b0, 1'b0, 32'd0, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    nchecks++;
    if ({gnt0, gnt1, done0, done1, mem_write, mem_read} !== 6'b0) begin
      errors++;
      $display("FAIL idle_after_reset: got gnt=%b%b done=%b%b mw=%b mr=%b, required all 0",
               gnt0, gnt1, done0, done1, mem_write, mem_read);
    end
    step();
  endtask

  task automatic test_reset_abort();
    bit got, seen_done;
    run_txn(0, 1'b1, 32'd4, 32'h1122_3344, "abort_setup_wr");
    drive(0, 1'b1, 1'b1, 32'd4, 32'hCAFE_F00D);
    got = 0;
    for (int i = 0; i < 8 && !got; i++) begin
      @(negedge clk);
      if (gnt0) got = 1;
    end
    @(negedge clk);
    nchecks++;
    if (!got || mem_write !== 1'b1) begin
      errors++;
      $display("FAIL abort_access: got gnt=%0b mem_write=%b, required 1 and 1", got, mem_write);
    end
    #1 rst = 1'b1;
    #1;
    nchecks++;
    if (mem_write !== 1'b0) begin
      errors++;
      $display("FAIL abort_mem_write_drop: got %b, required 0", mem_write);
    end
    drive(0, 1'b0, 1'b0, 32'd0, 32'd0);
    step();
    rst = 1'b0;
    seen_done = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (done0 || done1) seen_done = 1;
    end
    nchecks++;
    if (seen_done) begin
      errors++;
      $display("FAIL abort_no_done: got a done pulse, required none");
    end
    step();
    run_txn(0, 1'b0, 32'd4, 32'd0, "abort_readback");
  endtask

  task automatic test_write_read();
    run_txn(0, 1'b1, 32'd8, 32'hDEAD_BEEF, "wr8_p0");
    run_txn(0, 1'b0, 32'd8, 32'd0, "rd8_p0");
  endtask

  task automatic test_misaligned();
    run_txn(1, 1'b0, 32'd6, 32'd0, "misaligned_rd_p1");
    run_txn(0, 1'b1, 32'd1, 32'h5555_AAAA, "misaligned_wr_p0");
  endtask

  task automatic test_out_of_range();
    run_txn(0, 1'b0, 32'd12, 32'd0, "range_12");
    run_txn(0, 1'b1, 32'hFFFF_FFFC, 32'h0BAD_0BAD, "range_wrap");
    run_txn(0, 1'b0, 32'd0, 32'd0, "range_word0_intact");
  endtask

  task automatic test_port1();
    run_txn(1, 1'b1, 32'd0, 32'hA5A5_0001, "p1_wr0");
    run_txn(1, 1'b0, 32'd0, 32'd0, "p1_rd0");
  endtask

  task automatic test_contention();
    bit got, fin;
    int win, exp_win;
    logic [31:0] rd;
    do_reset();
    drive(0, 1'b1, 1'b0, 32'd0, 32'd0);
    drive(1, 1'b1, 1'b0, 32'd4, 32'd0);
    for (int k = 0; k < 5; k++) begin
`ifdef ROUND_ROBIN_EN
      exp_win = (k == 4) ? 1 : k % 2;
`else
      exp_win = (k == 4) ? 1 : 0;
`endif
      got = 0; win = -1;
      for (int i = 0; i < 8 && !got; i++) begin
        @(negedge clk);
        if (gnt0 || gnt1) begin
          got = 1;
          win = (gnt0 && gnt1) ? 2 : (gnt1 ? 1 : 0);
        end
      end
      nchecks++;
      if (win != exp_win) begin
        errors++;
        $display("FAIL contention_grant_%0d: got port %0d, required port %0d", k, win, exp_win);
      end
      fin = 0; rd = 0;
      for (int i = 0; i < 4 && !fin; i++) begin
        @(negedge clk);
        if (done0 || done1) begin fin = 1; rd = done1 ? rdata1 : rdata0; end
      end
      nchecks++;
      if (!fin || rd !== ref_mem[exp_win]) begin
        errors++;
        $display("FAIL contention_rdata_%0d: got done=%0b rdata=%h, required 1 and %h",
                 k, fin, rd, ref_mem[exp_win]);
      end
      if (k == 3) drive(0, 1'b0, 1'b0, 32'd0, 32'd0);
    end
    drive(1, 1'b0, 1'b0, 32'd0, 32'd0);
    step();
  endtask

  task automatic test_random();
    int p, sel;
    logic w;
    logic [31:0] a;
    for (int n = 0; n < 24; n++) begin
      p   = int'($urandom_range(0, 1));
      w   = 1'($urandom_range(0, 1));
      sel = int'($urandom_range(0, 5));
      case (sel)
        0, 1, 2: a = 32'(sel * 4);
        3:       a = 32'($urandom_range(0, 15));
        4:       a = $urandom();
        default: a = 32'($urandom_range(0, 2) * 4);
      endcase
      run_txn(p, w, a, $urandom(), $sformatf("rand_%0d", n));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 12; i++) mem_b[i] = 8'h00;
    for (int i = 0; i < 3; i++)  ref_mem[i] = 32'h0;
    drive(0, 1'b0, 1'b0, 32'd0, 32'd0);
    drive(1, 1'b0, 1'b0, 32'd0, 32'd0);
    test_reset();
    test_reset_abort();
    test_write_read();
    test_misaligned();
    test_out_of_range();
    test_port1();
    test_contention();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, nchecks);
    $finish;
  end

endmodule
